alu_share_arbiter: RTL and testbench

Shares one combinational ALU instance between NREQ requesters, such as a pipeline execute stage and an address/branch helper unit. The block arbitrates round-robin, captures one request's operands and opcode, evaluates them, and returns a registered result with requester ID over a valid/ready response channel. Only one transaction is outstanding at a time; there is no queuing.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_share_arbiter_if.sv | 30 +++
 rtl/alu.sv | 32 +++
 rtl/rr_pick.sv | 37 +++
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath widths, arbiter FSM states
// and the opcode legality check.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int SHAMT_W = 5;
  localparam int CTRL_W  = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [CTRL_W-1:0] ctrl);
    return (ctrl <= 4'd9);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters, the response consumer and
// the shared-ALU arbiter; request fields are flattened per requester.
interface alu_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_op1;
  logic [NREQ*32-1:0] req_op2;
  logic [NREQ*4-1:0]  req_ctrl;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_result;
  logic               rsp_zero;
  logic               rsp_illegal;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_id
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_id
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; unknown opcodes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [ALU_W-1:0]  op1,
  input  logic [ALU_W-1:0]  op2,
  output logic [ALU_W-1:0]  result
);

  logic [SHAMT_W-1:0] shamt_s;
  assign shamt_s = op2[SHAMT_W-1:0];

  // Opcode decode and evaluation
  always_comb begin
    result = {ALU_W{1'b0}};
    case (alu_op_e'(ctrl))
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_SLL:  result = op1 << shamt_s;
      ALU_SRL:  result = op1 >> shamt_s;
      ALU_SRA:  result = $unsigned($signed(op1) >>> shamt_s);
      ALU_SLT:  result = {{(ALU_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: result = {{(ALU_W-1){1'b0}}, (op1 < op2)};
      default:  result = {ALU_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index scanning upward from
// last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_idx
);

  logic           found_s;
  int             cand_s;
  logic [IDW-1:0] cand_idx_s;

  // Rotating priority scan
  always_comb begin
    grant_onehot = {NREQ{1'b0}};
    grant_idx    = {IDW{1'b0}};
    found_s      = 1'b0;
    cand_s       = 0;
    cand_idx_s   = {IDW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand_s     = (int'(last) + i) % NREQ;
      cand_idx_s = cand_s[IDW-1:0];
      if (!found_s && valid[cand_idx_s]) begin
        found_s                  = 1'b1;
        grant_onehot[cand_idx_s] = 1'b1;
        grant_idx                = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters; one transaction in
// flight, registered result returned on a valid/ready response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  output logic               busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [IDW-1:0]    last_grant_r;
  logic [ALU_W-1:0]  op1_r;
  logic [ALU_W-1:0]  op2_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic              rsp_valid_r;
  logic [ALU_W-1:0]  rsp_result_r;
  logic              rsp_zero_r;
  logic              rsp_illegal_r;
  logic [IDW-1:0]    rsp_id_r;

  logic [NREQ-1:0]   grant_onehot_s;
  logic [IDW-1:0]    grant_idx_s;
  logic [NREQ-1:0]   req_ready_s;
  logic              any_valid_s;
  logic [ALU_W-1:0]  alu_res_s;

  assign any_valid_s = |bus.req_valid;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .valid       (bus.req_valid),
    .last        (last_grant_r),
    .grant_onehot(grant_onehot_s),
    .grant_idx   (grant_idx_s)
  );

  alu u_alu (
    .ctrl  (ctrl_r),
    .op1   (op1_r),
    .op2   (op2_r),
    .result(alu_res_s)
  );

  // Next-state and grant decode
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_nxt_s = ST_EXEC;
          req_ready_s = grant_onehot_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_r && bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= IDW'(NREQ - 1);
      op1_r         <= {ALU_W{1'b0}};
      op2_r         <= {ALU_W{1'b0}};
      ctrl_r        <= {CTRL_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_result_r  <= {ALU_W{1'b0}};
      rsp_zero_r    <= 1'b0;
      rsp_illegal_r <= 1'b0;
      rsp_id_r      <= {IDW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            op1_r        <= bus.req_op1[int'(grant_idx_s)*ALU_W +: ALU_W];
            op2_r        <= bus.req_op2[int'(grant_idx_s)*ALU_W +: ALU_W];
            ctrl_r       <= bus.req_ctrl[int'(grant_idx_s)*CTRL_W +: CTRL_W];
            last_grant_r <= grant_idx_s;
          end
        end
        ST_EXEC: begin
          rsp_result_r  <= alu_res_s;
          rsp_zero_r    <= (alu_res_s == {ALU_W{1'b0}});
          rsp_illegal_r <= !alu_op_legal(ctrl_r);
          rsp_id_r      <= last_grant_r;
          rsp_valid_r   <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  // Reset forces the request side and busy low combinationally
  assign bus.req_ready   = rst ? {NREQ{1'b0}} : req_ready_s;
  assign busy            = (state_r != ST_IDLE) && !rst;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_result  = rsp_result_r;
  assign bus.rsp_zero    = rsp_zero_r;
  assign bus.rsp_illegal = rsp_illegal_r;
  assign bus.rsp_id      = rsp_id_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and seeded-random checks of alu_share_arbiter with four requesters.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  alu_share_arbiter_if #(.NREQ(N)) ifc ();

  alu_share_arbiter #(.NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    ifc.req_valid[i]          = v;
    ifc.req_op1[i*32 +: 32]   = a;
    ifc.req_op2[i*32 +: 32]   = b;
    ifc.req_ctrl[i*4 +: 4]    = c;
  endtask

  function automatic int rr_model(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ifc.req_valid = 4'b0000;
    ifc.req_op1 = '0;
    ifc.req_op2 = '0;
    ifc.req_ctrl = '0;
    ifc.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
    #1;
    checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready0 got %b want 0000", ifc.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b want 0", busy); end
    tick();
    tick();
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", ifc.rsp_valid); end
    checks++; if (ifc.rsp_result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", ifc.rsp_result); end
    checks++; if (ifc.rsp_zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b want 0", ifc.rsp_zero); end
    checks++; if (ifc.rsp_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", ifc.rsp_illegal); end
    checks++; if (ifc.rsp_id !== 2'd0) begin errors++; $display("FAIL rst_id got %0d want 0", ifc.rsp_id); end
    checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready1 got %b want 0000", ifc.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy1 got %b want 0", busy); end
    rst = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b want 0000", ifc.req_ready); end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 32'd5, 32'd7, 4'd0);
    ifc.rsp_ready = 1'b1;
    #1;
    checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", ifc.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec got %b want 1", busy); end
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_exec got %b want 0", ifc.rsp_valid); end
    tick();
    checks++; if (ifc.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", ifc.rsp_valid); end
    checks++; if (ifc.rsp_result !== 32'd12) begin errors++; $display("FAIL single_result got %h want 0000000c", ifc.rsp_result); end
    checks++; if (ifc.rsp_zero !== 1'b0) begin errors++; $display("FAIL single_zero got %b want 0", ifc.rsp_zero); end
    checks++; if (ifc.rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", ifc.rsp_id); end
    tick();
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_done got %b want 0", ifc.rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got %b want 0", busy); end
    checks++; if (ifc.rsp_result !== 32'd12) begin errors++; $display("FAIL single_result_hold got %h want 0000000c", ifc.rsp_result); end
  endtask

  task automatic test_contention();
    // last grant was requester 0, so requester 1 goes first
    set_req(0, 1'b1, 32'd3, 32'd3, 4'd1);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd8);
    ifc.rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int          g;
      logic [3:0]  oh;
      g  = (t % 2 == 0) ? 1 : 0;
      oh = 4'b0001 << g;
      #1;
      checks++; if (ifc.req_ready !== oh) begin errors++; $display("FAIL cont_ready[%0d] got %b want %b", t, ifc.req_ready, oh); end
      tick();
      tick();
      checks++; if (ifc.rsp_id !== g[1:0]) begin errors++; $display("FAIL cont_id[%0d] got %0d want %0d", t, ifc.rsp_id, g); end
      checks++; if (ifc.rsp_result !== ((g == 1) ? 32'd1 : 32'd0)) begin errors++; $display("FAIL cont_result[%0d] got %h want %0d", t, ifc.rsp_result, g); end
      checks++; if (ifc.rsp_zero !== (g == 0)) begin errors++; $display("FAIL cont_zero[%0d] got %b want %b", t, ifc.rsp_zero, (g == 0)); end
      tick();
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic test_backpressure();
    set_req(2, 1'b1, 32'h8000_0000, 32'd4, 4'd7);
    ifc.rsp_ready = 1'b0;
    #1;
    checks++; if (ifc.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b want 0100", ifc.req_ready); end
    tick();
    // operands changed while busy must not leak into the result
    set_req(2, 1'b1, 32'h1234_5678, 32'd1, 4'd0);
    checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_exec got %b want 0000", ifc.req_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (ifc.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, ifc.rsp_valid); end
      checks++; if (ifc.rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL bp_result[%0d] got %h want f8000000", k, ifc.rsp_result); end
      checks++; if (ifc.rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id[%0d] got %0d want 2", k, ifc.rsp_id); end
      checks++; if (ifc.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", k, ifc.req_ready); end
      tick();
    end
    set_req(2, 1'b0, 32'd0, 32'd0, 4'd0);
    ifc.rsp_ready = 1'b1;
    #1;
    checks++; if (ifc.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_pre got %b want 1", ifc.rsp_valid); end
    tick();
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_done got %b want 0", ifc.rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_done got %b want 0", busy); end
    checks++; if (ifc.rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL bp_result_hold got %h want f8000000", ifc.rsp_result); end
  endtask

  task automatic test_edge_ops();
    logic [31:0] va [11];
    logic [31:0] vb [11];
    logic [31:0] vr [11];
    logic [3:0]  vc [11];
    logic        vz [11];
    logic        vi [11];
    va[0]  = 32'd1;         vb[0]  = 32'd33;       vc[0]  = 4'd5;  vr[0]  = 32'd2;         vz[0]  = 1'b0; vi[0]  = 1'b0;
    va[1]  = 32'hFFFF_FFFF; vb[1]  = 32'd1;        vc[1]  = 4'd9;  vr[1]  = 32'd0;         vz[1]  = 1'b1; vi[1]  = 1'b0;
    va[2]  = 32'hFFFF_FFFF; vb[2]  = 32'd1;        vc[2]  = 4'd0;  vr[2]  = 32'd0;         vz[2]  = 1'b1; vi[2]  = 1'b0;
    va[3]  = 32'd5;         vb[3]  = 32'd5;        vc[3]  = 4'd12; vr[3]  = 32'd0;         vz[3]  = 1'b1; vi[3]  = 1'b1;
    va[4]  = 32'h0000_F0F0; vb[4]  = 32'h0000_FF00; vc[4] = 4'd2;  vr[4]  = 32'h0000_F000; vz[4]  = 1'b0; vi[4]  = 1'b0;
    va[5]  = 32'h0000_F0F0; vb[5]  = 32'h0000_FF00; vc[5] = 4'd3;  vr[5]  = 32'h0000_FFF0; vz[5]  = 1'b0; vi[5]  = 1'b0;
    va[6]  = 32'h0000_F0F0; vb[6]  = 32'h0000_FF00; vc[6] = 4'd4;  vr[6]  = 32'h0000_0FF0; vz[6]  = 1'b0; vi[6]  = 1'b0;
    va[7]  = 32'h8000_0000; vb[7]  = 32'd31;       vc[7]  = 4'd6;  vr[7]  = 32'd1;         vz[7]  = 1'b0; vi[7]  = 1'b0;
    va[8]  = 32'hFFFF_FFFF; vb[8]  = 32'd1;        vc[8]  = 4'd8;  vr[8]  = 32'd1;         vz[8]  = 1'b0; vi[8]  = 1'b0;
    va[9]  = 32'd0;         vb[9]  = 32'd1;        vc[9]  = 4'd1;  vr[9]  = 32'hFFFF_FFFF; vz[9]  = 1'b0; vi[9]  = 1'b0;
    va[10] = 32'd9;         vb[10] = 32'd9;        vc[10] = 4'd15; vr[10] = 32'd0;         vz[10] = 1'b1; vi[10] = 1'b1;
    ifc.rsp_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      set_req(3, 1'b1, va[v], vb[v], vc[v]);
      #1;
      checks++; if (ifc.req_ready !== 4'b1000) begin errors++; $display("FAIL edge_ready[%0d] got %b want 1000", v, ifc.req_ready); end
      tick();
      set_req(3, 1'b0, 32'd0, 32'd0, 4'd0);
      tick();
      checks++; if (ifc.rsp_result !== vr[v]) begin errors++; $display("FAIL edge_result[%0d] got %h want %h", v, ifc.rsp_result, vr[v]); end
      checks++; if (ifc.rsp_zero !== vz[v]) begin errors++; $display("FAIL edge_zero[%0d] got %b want %b", v, ifc.rsp_zero, vz[v]); end
      checks++; if (ifc.rsp_illegal !== vi[v]) begin errors++; $display("FAIL edge_illegal[%0d] got %b want %b", v, ifc.rsp_illegal, vi[v]); end
      checks++; if (ifc.rsp_id !== 2'd3) begin errors++; $display("FAIL edge_id[%0d] got %0d want 3", v, ifc.rsp_id); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b1, 32'd1, 32'd1, 4'd0);
    ifc.rsp_ready = 1'b1;
    #1;
    checks++; if (ifc.req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_grant got %b want 0010", ifc.req_ready); end
    tick();
    rst = 1'b1;
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_rst got %b want 0", busy); end
    tick();
    rst = 1'b0;
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid0 got %b want 0", ifc.rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy0 got %b want 0", busy); end
    tick();
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid1 got %b want 0", ifc.rsp_valid); end
    set_req(0, 1'b1, 32'd10, 32'd20, 4'd0);
    set_req(1, 1'b1, 32'd7, 32'd7, 4'd1);
    #1;
    checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_regrant got %b want 0001", ifc.req_ready); end
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    checks++; if (ifc.rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid2 got %b want 1", ifc.rsp_valid); end
    checks++; if (ifc.rsp_result !== 32'd30) begin errors++; $display("FAIL midrst_result got %h want 0000001e", ifc.rsp_result); end
    checks++; if (ifc.rsp_id !== 2'd0) begin errors++; $display("FAIL midrst_id got %0d want 0", ifc.rsp_id); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  pending;
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    logic [3:0]  rc [4];
    int          waits [4];
    int          last;
    int          g;
    int          stall;
    logic [31:0] exp_r;
    pending = 4'b0000;
    last    = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1'b1;
          ra[i] = $urandom;
          rb[i] = $urandom;
          rc[i] = 4'($urandom_range(0, 15));
          waits[i] = 0;
          set_req(i, 1'b1, ra[i], rb[i], rc[i]);
        end
      end
      if (pending == 4'b0000) begin
        g = $urandom_range(0, 3);
        pending[g] = 1'b1;
        ra[g] = $urandom;
        rb[g] = 32'd3;
        rc[g] = 4'd7;
        waits[g] = 0;
        set_req(g, 1'b1, ra[g], rb[g], rc[g]);
      end
      #1;
      g = rr_model(pending, last);
      exp_r = ref_alu(rc[g], ra[g], rb[g]);
      checks++; if (ifc.req_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rnd_grant[%0d] got %b want %0d", t, ifc.req_ready, g); end
      checks++; if (waits[g] > 3) begin errors++; $display("FAIL rnd_fair[%0d] got wait %0d want <=3", t, waits[g]); end
      tick();
      pending[g] = 1'b0;
      ifc.req_valid[g] = 1'b0;
      for (int i = 0; i < 4; i++) if (pending[i]) waits[i]++;
      last = g;
      stall = $urandom_range(0, 2);
      ifc.rsp_ready = (stall == 0);
      tick();
      for (int s = 0; s < stall; s++) tick();
      ifc.rsp_ready = 1'b1;
      checks++; if (ifc.rsp_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d] got %b want 1", t, ifc.rsp_valid); end
      checks++; if (ifc.rsp_result !== exp_r) begin errors++; $display("FAIL rnd_result[%0d] got %h want %h", t, ifc.rsp_result, exp_r); end
      checks++; if (ifc.rsp_zero !== (exp_r == 32'd0)) begin errors++; $display("FAIL rnd_zero[%0d] got %b want %b", t, ifc.rsp_zero, (exp_r == 32'd0)); end
      checks++; if (ifc.rsp_illegal !== (rc[g] > 4'd9)) begin errors++; $display("FAIL rnd_illegal[%0d] got %b want %b", t, ifc.rsp_illegal, (rc[g] > 4'd9)); end
      checks++; if (ifc.rsp_id !== g[1:0]) begin errors++; $display("FAIL rnd_id[%0d] got %0d want %0d", t, ifc.rsp_id, g); end
      tick();
      checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_valid_done[%0d] got %b want 0", t, ifc.rsp_valid); end
    end
    ifc.req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_edge_ops();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
